// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-cathode multi-digit 7-segment display.
// Build macro LEADING_ZERO_BLANK_EN: when defined, leading zero digits are kept dark (digit 0 always lit).

module seven_seg_scan_ctrl #(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int BLANK_CYCLES = 500
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   input  logic                    load_req,
   output logic                    load_ready,
   output logic [3:0]              bin_out,
   output logic [NUM_DIGITS-1:0]   digit_sel,
   output logic                    blank,
   output logic                    frame_done
);

   localparam int CNT_MAX0 = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
   localparam int CNT_MAX  = (CNT_MAX0 > 2) ? CNT_MAX0 : 2;
   localparam int CW       = $clog2(CNT_MAX);
   localparam int IW       = $clog2(NUM_DIGITS);
   localparam int VW       = 4 * NUM_DIGITS;

   localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
   localparam logic [CW-1:0] BLANK_LAST = (BLANK_CYCLES > 0) ? CW'(BLANK_CYCLES - 1) : '0;
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_SHOW  = 2'd1,
      S_BLANK = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [VW-1:0]   shadow_q, shadow_d;
   logic [VW-1:0]   pend_q, pend_d;
   logic            pend_valid_q, pend_valid_d;

   logic            advance;
   logic            boundary;
   logic [NUM_DIGITS-1:0] lit_mask;

   // Handshake: load_ready is high whenever no value is pending; an edge with
   // load_req=1 and load_ready=1 captures value_in, otherwise load_req is ignored.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      advance      = 1'b0;
      boundary     = 1'b0;

      case (state_q)
         S_INIT: begin
            state_d  = S_SHOW;
            idx_d    = '0;
            cnt_d    = '0;
            boundary = 1'b1;
         end
         S_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               cnt_d = '0;
               if (BLANK_CYCLES == 0) begin
                  advance = 1'b1;
               end else begin
                  state_d = S_BLANK;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_BLANK: begin
            if (cnt_q == BLANK_LAST) begin
               cnt_d   = '0;
               state_d = S_SHOW;
               advance = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_INIT;
      endcase

      // Wrapping back to digit 0 is the frame boundary.
      if (advance) begin
         if (idx_q == IDX_LAST) begin
            idx_d    = '0;
            boundary = 1'b1;
         end else begin
            idx_d = idx_q + 1'b1;
         end
      end

      if (boundary && pend_valid_q) begin
         shadow_d     = pend_q;
         pend_valid_d = 1'b0;
      end

      if (load_req && !pend_valid_q) begin
         pend_d       = value_in;
         pend_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_INIT;
         idx_q        <= '0;
         cnt_q        <= '0;
         shadow_q     <= '0;
         pend_q       <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         pend_q       <= pend_d;
         pend_valid_q <= pend_valid_d;
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic nz_above;

   // A digit stays lit if it or any more-significant nibble is non-zero.
   always_comb begin
      nz_above = 1'b0;
      lit_mask = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         nz_above    = nz_above | (|shadow_q[4*i +: 4]);
         lit_mask[i] = nz_above | (i == 0);
      end
   end
`else
   assign lit_mask = '1;
`endif

   always_comb begin
      digit_sel = '0;
      bin_out   = 4'h0;
      if (state_q == S_SHOW) begin
         bin_out = shadow_q[4*idx_q +: 4];
         if (lit_mask[idx_q]) begin
            digit_sel = NUM_DIGITS'(1) << idx_q;
         end
      end
   end

   assign blank      = ~|digit_sel;
   assign frame_done = (state_q == S_SHOW) && (idx_q == '0) && (cnt_q == '0);
   assign load_ready = ~pend_valid_q;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Self-checking bench for seven_seg_scan_ctrl: frame timeline model plus a queue of values
// awaiting display, popped at each frame boundary.

module tb_seven_seg_scan_ctrl;

   localparam int ND    = 4;
   localparam int RD    = 4;
   localparam int BC    = 1;
   localparam int SLOT  = RD + BC;
   localparam int FRAME = ND * SLOT;

   logic            clk;
   logic            rst;
   logic [4*ND-1:0] value_in;
   logic            load_req;
   logic            load_ready;
   logic [3:0]      bin_out;
   logic [ND-1:0]   digit_sel;
   logic            blank;
   logic            frame_done;

   int              n_pass;
   int              n_total;
   int              phase;
   logic [15:0]     shown;
   logic [15:0]     exp_q[$];

   seven_seg_scan_ctrl #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RD),
      .BLANK_CYCLES (BC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .value_in   (value_in),
      .load_req   (load_req),
      .load_ready (load_ready),
      .bin_out    (bin_out),
      .digit_sel  (digit_sel),
      .blank      (blank),
      .frame_done (frame_done)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // expected outputs from the frame timeline
   function automatic logic [ND-1:0] e_sel();
      int   d;
      int   s;
      logic lit;
      d = phase / SLOT;
      s = phase % SLOT;
`ifdef LEADING_ZERO_BLANK_EN
      lit = (d == 0) || ((shown >> (4*d)) != 16'h0);
`else
      lit = 1'b1;
`endif
      if (s < RD && lit) return ND'(1) << d;
      return '0;
   endfunction

   function automatic logic [3:0] e_bin();
      int d;
      int s;
      d = phase / SLOT;
      s = phase % SLOT;
      if (s < RD) return shown[4*d +: 4];
      return 4'h0;
   endfunction

   function automatic logic e_rdy();
      return exp_q.size() == 0;
   endfunction

   function automatic string got_str();
      return $sformatf("sel=%b bin=%h blank=%b fd=%b rdy=%b",
                       digit_sel, bin_out, blank, frame_done, load_ready);
   endfunction

   function automatic string exp_str();
      return $sformatf("sel=%b bin=%h blank=%b fd=%b rdy=%b",
                       e_sel(), e_bin(), (e_sel() == '0), (phase == 0), e_rdy());
   endfunction

   // driver: one clock, with scoreboard bookkeeping for the edge just taken
   task automatic clock_cycle();
      bit          acc;
      logic [15:0] v;
      acc = load_req && (exp_q.size() == 0);
      v   = value_in;
      @(posedge clk);
      #1;
      phase = (phase + 1) % FRAME;
      if (phase == 0 && exp_q.size() != 0) shown = exp_q.pop_front();
      if (acc) exp_q.push_back(v);
   endtask

   task automatic model_reset();
      exp_q.delete();
      shown = 16'h0;
      phase = FRAME - 1;
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      load_req = 1'b0;
      value_in = '0;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if (digit_sel !== '0 || bin_out !== 4'h0 || blank !== 1'b1 || frame_done !== 1'b0 || load_ready !== 1'b1) begin
         $display("FAIL reset_hold: got %s expected sel=0000 bin=0 blank=1 fd=0 rdy=1", got_str());
      end else n_pass++;
      rst = 1'b0;
      model_reset();
      n_total++;
      if (digit_sel !== '0 || bin_out !== 4'h0 || blank !== 1'b1 || frame_done !== 1'b0 || load_ready !== 1'b1) begin
         $display("FAIL init_cycle: got %s expected sel=0000 bin=0 blank=1 fd=0 rdy=1", got_str());
      end else n_pass++;
      for (int i = 0; i < 2*FRAME; i++) begin
         clock_cycle();
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL reset_scan phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
      end
   endtask

   task automatic test_load_mid_frame();
      for (int i = 0; i < 3*FRAME; i++) begin
         load_req = (i < FRAME) && (phase == 7);
         value_in = 16'h1234;
         clock_cycle();
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL load_mid_frame phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
      end
      load_req = 1'b0;
   endtask

   // Second request is held through the boundary edge where load_ready is still 0.
   task automatic test_first_wins();
      bit armed;
      bit stop;
      armed = 1'b0;
      stop  = 1'b0;
      for (int i = 0; i < 3*FRAME; i++) begin
         if (!armed && phase == 3) begin
            armed    = 1'b1;
            value_in = 16'h7E19;
         end else if (armed) begin
            value_in = 16'hABCD;
         end
         load_req = armed && !stop;
         clock_cycle();
         if (armed && phase == 0) stop = 1'b1;
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL first_wins phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
      end
      load_req = 1'b0;
   endtask

   task automatic test_boundary_load();
      for (int i = 0; i < 3*FRAME; i++) begin
         load_req = (i < FRAME) && (phase == FRAME - 1);
         value_in = 16'h5678;
         clock_cycle();
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL boundary_load phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
      end
      load_req = 1'b0;
   endtask

   task automatic test_leading_zero();
      logic [15:0] vals [3];
      vals[0] = 16'h0050;
      vals[1] = 16'h0000;
      vals[2] = 16'h0300;
      for (int i = 0; i < 4*FRAME; i++) begin
         load_req = (i < 3*FRAME) && (phase == 5);
         value_in = (i < 3*FRAME) ? vals[i / FRAME] : 16'h0;
         clock_cycle();
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL leading_zero phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
      end
      load_req = 1'b0;
   endtask

   task automatic test_random();
      int          rp;
      logic [15:0] rv;
      rp = 9;
      rv = 16'hC0DE;
      for (int i = 0; i < 4*FRAME; i++) begin
         if (phase == 0) begin
            rp = $urandom_range(1, FRAME - 2);
            rv = 16'($urandom_range(0, 65535));
         end
         if (phase == rp) begin
            load_req = 1'b1;
            value_in = rv;
         end else if (phase > rp) begin
            load_req = 1'($urandom_range(0, 1));
            value_in = 16'($urandom_range(0, 65535));
         end else begin
            load_req = 1'b0;
         end
         clock_cycle();
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL random phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
      end
      load_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < FRAME; i++) begin
         load_req = (phase == 1);
         value_in = 16'h9999;
         clock_cycle();
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL reset_mid_pre phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
         if (phase == 7) break;
      end
      load_req = 1'b0;
      n_total++;
      if (load_ready !== 1'b0 || digit_sel === '0) begin
         $display("FAIL reset_mid_setup: got %s expected rdy=0 and a lit digit", got_str());
      end else n_pass++;
      rst = 1'b1;
      #2;
      n_total++;
      if (digit_sel !== '0 || bin_out !== 4'h0 || blank !== 1'b1 || frame_done !== 1'b0 || load_ready !== 1'b1) begin
         $display("FAIL reset_async: got %s expected sel=0000 bin=0 blank=1 fd=0 rdy=1", got_str());
      end else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
      n_total++;
      if (digit_sel !== '0 || bin_out !== 4'h0 || blank !== 1'b1 || frame_done !== 1'b0 || load_ready !== 1'b1) begin
         $display("FAIL reset_mid_init: got %s expected sel=0000 bin=0 blank=1 fd=0 rdy=1", got_str());
      end else n_pass++;
      for (int i = 0; i < 2*FRAME; i++) begin
         clock_cycle();
         n_total++;
         if (digit_sel !== e_sel() || bin_out !== e_bin() || blank !== (e_sel() == '0) ||
             frame_done !== (phase == 0) || load_ready !== e_rdy()) begin
            $display("FAIL reset_mid_post phase=%0d: got %s expected %s", phase, got_str(), exp_str());
         end else n_pass++;
      end
   endtask

   initial begin
      rst      = 1'b1;
      load_req = 1'b0;
      value_in = '0;
      n_pass   = 0;
      n_total  = 0;
      model_reset();

      test_reset();
      test_load_mid_frame();
      test_first_wins();
      test_boundary_load();
      test_leading_zero();
      test_random();
      test_reset_mid();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/seven_seg_scan_ctrl.md
Name: seven_seg_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-cathode multi-digit 7-segment display. Holds a packed NUM_DIGITS x 4-bit value and presents one nibble at a time on bin_out to the existing binary_to_7segments decoder, while driving a one-hot digit select. A ready/request handshake updates the value; updates take effect only at frame boundaries, so the display never tears. Sits between the system datapath and the decoder/pad ring.

Parameters:
NUM_DIGITS, 4, number of digits scanned (2..8).
REFRESH_DIV, 50000, clock cycles each digit is lit per frame (>=1).
BLANK_CYCLES, 500, dead-time cycles with all digits off after each digit (>=0; 0 = no dead-time).

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
value_in  input  4*NUM_DIGITS  packed value; nibble i = digit i; digit 0 = bits [3:0], rightmost.
load_req  input  1  request to load value_in; sampled when load_ready=1.
load_ready  output  1  high when a new value can be accepted.
bin_out  output  4  nibble for the decoder.
digit_sel  output  NUM_DIGITS  one-hot active-high digit enable; all-zero when dark.
blank  output  1  high when digit_sel is all-zero.
frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock is clk; reset is rst, asynchronous, active-high. Clock and reset are the only timing inputs.
- Registers: state {INIT, SHOW, BLANK}, digit index idx, cycle counter cnt (width $clog2(max(REFRESH_DIV,BLANK_CYCLES,2))), shadow (displayed value), pend (captured value), pend_valid.
- Reset (asserts immediately, not clock-gated): state=INIT, idx=0, cnt=0, shadow=0, pend=0, pend_valid=0. Outputs during and after reset until INIT is left: digit_sel=0, bin_out=0, blank=1, frame_done=0, load_ready=1.
- INIT: lasts exactly one cycle after rst falls, then goes to SHOW with idx=0. This transition is a frame boundary.
- SHOW: digit_sel=onehot(idx), bin_out=shadow[4*idx+:4]. Lasts REFRESH_DIV cycles (cnt 0..REFRESH_DIV-1). Then goes to BLANK, or directly to next digit's SHOW if BLANK_CYCLES=0.
- BLANK: digit_sel=0, bin_out=0. Lasts BLANK_CYCLES cycles, then SHOW of idx+1. idx wraps from NUM_DIGITS-1 to 0; that wrap is a frame boundary.
- Frame length = NUM_DIGITS*(REFRESH_DIV+BLANK_CYCLES) cycles.
- Frame boundary: if pend_valid, shadow<=pend and pend_valid<=0 at the same edge. frame_done is high for exactly the first cycle of digit-0 SHOW, and shadow already holds the new value in that cycle.
- Handshake: load_ready = !pend_valid (combinational from register). On an edge with load_req=1 and load_ready=1: pend<=value_in, pend_valid<=1. load_req while load_ready=0 is ignored; the earlier pending value is kept (first-wins).
- Simultaneous capture and boundary with pend_valid=0: value goes to pend only and is shown from the next frame's boundary.
- Boundary with pend_valid=1 and load_req=1 on the same edge: load_ready was 0, so the request is ignored; load_ready rises the following cycle.
- Outputs are glitch-free decodes of registered state; no combinational path from value_in or load_req to any display output.

Optional Feature:
Macro LEADING_ZERO_BLANK_EN. Defined: during SHOW of digit i>0, digit_sel=0 (and blank=1) if shadow nibbles i..NUM_DIGITS-1 are all zero; digit 0 is never suppressed; timing and frame length are unchanged. Not defined: every digit is lit in its SHOW slot regardless of value.

Test Plan:
(All with NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1.)
1. rst high then released -> all outputs at reset values; 1 INIT cycle; digit_sel=0001 for 4 cycles, 0000 for 1, 0010 for 4, ...; frame_done pulses every 20 cycles; bin_out=0 throughout.
2. Mid-frame load_req=1 with value_in=0x1234 for 1 cycle -> load_ready=0 next cycle; display unchanged until boundary; then frame_done with digits 0..3 showing 4,3,2,1; load_ready=1 one cycle after boundary.
3. Load 0x1234, then load_req with 0xABCD while load_ready=0 -> 0xABCD ignored; next frame shows 0x1234.
4. load_req with 0x5678 on the exact boundary edge, pend_valid=0 -> current frame shows old value; 0x5678 appears at the following boundary (20 cycles later).
5. rst asserted mid-SHOW after a pending load -> digit_sel=0, bin_out=0 and load_ready=1 immediately without a clock edge; after release the display shows 0 (pend discarded).
6. LEADING_ZERO_BLANK_EN defined, shadow=0x0050 -> digits 3 and 2 dark, digit 1 shows 5, digit 0 shows 0; shadow=0x0000 -> only digit 0 lit, showing 0.
